// File: rtl/ibus_arbiter_pkg.sv
// Shared types and helpers for the two-master internal-bus arbiter.
package ibus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } ibus_arb_state_t;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Winner when leaving IDLE. A tie goes to M0 in fixed mode, or to the master
  // that did not complete last in round-robin mode.
  function automatic ibus_arb_state_t pick_owner(input logic req0, input logic req1,
                                                 input logic last_m1, input logic rr);
    if (req0 && req1) begin
      if (rr && !last_m1) return ARB_OWN1;
      return ARB_OWN0;
    end
    if (req0) return ARB_OWN0;
    if (req1) return ARB_OWN1;
    return ARB_IDLE;
  endfunction

  // Grant decision once the current owner has finished (or gone quiet) and is not
  // locking. In fixed mode only M0 may take the bus away from a still-requesting owner.
  function automatic ibus_arb_state_t rearb(input logic own_m1, input logic req_own,
                                            input logic req_oth, input logic rr);
    ibus_arb_state_t own_s;
    ibus_arb_state_t oth_s;
    own_s = own_m1 ? ARB_OWN1 : ARB_OWN0;
    oth_s = own_m1 ? ARB_OWN0 : ARB_OWN1;
    if (req_oth && (rr || own_m1)) return oth_s;
    if (!req_own && req_oth) return oth_s;
    if (!req_own) return ARB_IDLE;
    return own_s;
  endfunction

  function automatic logic [1:0] owner_onehot(input ibus_arb_state_t s);
    case (s)
      ARB_OWN0: return 2'b01;
      ARB_OWN1: return 2'b10;
      default:  return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/ibus_arbiter.sv
// Two-master IBUS arbiter in front of the bus state controller. M0 is the DMAC,
// M1 the CPU/cache. The granted master is muxed onto the slave port; the other
// master is stalled. LOCK pins the grant so read-modify-write pairs stay atomic.
module ibus_arbiter
  import ibus_arbiter_pkg::*;
#(
  parameter int RR_MODE = ARB_FIXED
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CE_R,
  input  logic        CE_F,
  input  logic [31:0] M0_A,
  input  logic [31:0] M0_DI,
  input  logic [3:0]  M0_BA,
  input  logic        M0_WE,
  input  logic        M0_REQ,
  input  logic        M0_LOCK,
  output logic [31:0] M0_DO,
  output logic        M0_BUSY,
  input  logic [31:0] M1_A,
  input  logic [31:0] M1_DI,
  input  logic [3:0]  M1_BA,
  input  logic        M1_WE,
  input  logic        M1_REQ,
  input  logic        M1_LOCK,
  output logic [31:0] M1_DO,
  output logic        M1_BUSY,
  output logic [31:0] S_A,
  output logic [31:0] S_DI,
  output logic [3:0]  S_BA,
  output logic        S_WE,
  output logic        S_REQ,
  output logic        S_LOCK,
  input  logic [31:0] S_DO,
  input  logic        S_BUSY,
  output logic [1:0]  OWNER
);

  localparam logic RR = (RR_MODE == ARB_RR);

  ibus_arb_state_t state;
  ibus_arb_state_t next_state;
  logic            acc;       // slave access in flight
  logic            last_m1;   // last completed owner was M1
  logic            own_m1;
  logic            own_req;
  logic            oth_req;
  logic            own_lock;
  logic            done;

  // The falling-phase enable exists only for port uniformity with other IBUS blocks.
  logic unused_ce_f;
  assign unused_ce_f = CE_F;

  // Read data goes to both masters unqualified; BUSY tells each one when it is valid.
  assign M0_DO = S_DO;
  assign M1_DO = S_DO;

  // Slave-port mux, per-master stall and next grant, all from the current owner.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    own_m1     = (state == ARB_OWN1);
    own_req    = own_m1 ? M1_REQ  : M0_REQ;
    oth_req    = own_m1 ? M0_REQ  : M1_REQ;
    own_lock   = own_m1 ? M1_LOCK : M0_LOCK;
    done       = CE_R & acc & ~S_BUSY;
    S_A        = '0;
    S_DI       = '0;
    S_BA       = '0;
    S_WE       = 1'b0;
    S_REQ      = 1'b0;
    S_LOCK     = 1'b0;
    M0_BUSY    = M0_REQ;
    M1_BUSY    = M1_REQ;
    next_state = state;

    if (state == ARB_IDLE) begin
      next_state = pick_owner(M0_REQ, M1_REQ, last_m1, RR);
    end else begin
      S_A    = own_m1 ? M1_A    : M0_A;
      S_DI   = own_m1 ? M1_DI   : M0_DI;
      S_BA   = own_m1 ? M1_BA   : M0_BA;
      S_WE   = own_m1 ? M1_WE   : M0_WE;
      S_LOCK = own_lock;
      // Dropping the request on the completing cycle keeps the BSC from seeing
      // a spurious new access before ACC has cleared.
      S_REQ  = own_req & ~done;
      // The issue cycle itself is never a completion, even if the BSC is not busy.
      if (own_m1) M1_BUSY = own_req & (~acc | S_BUSY);
      else        M0_BUSY = own_req & (~acc | S_BUSY);
      if ((done || (!acc && !own_req)) && !own_lock)
        next_state = rearb(own_m1, own_req, oth_req, RR);
    end
  end

  // Grant, access-in-flight and round-robin history; everything advances only on CE_R.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= ARB_IDLE;
      acc     <= 1'b0;
      last_m1 <= 1'b1;
      OWNER   <= 2'b00;
    end else if (CE_R) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state <= next_state;
      OWNER <= owner_onehot(next_state);
      if (done) begin
        acc     <= 1'b0;
        last_m1 <= own_m1;
      end else if (S_REQ && !acc) begin
        acc <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ibus_arbiter.sv
// Bench for ibus_arbiter: one fixed-priority and one round-robin instance, a
// small BSC model with programmable wait states, master drivers, and a
// scoreboard that checks every completion against hand-written expectations.
module tb_ibus_arbiter;
  import ibus_arbiter_pkg::*;

  localparam logic [31:0] RD_KEY = 32'h5A5A_5A5A;  // BSC read data = address ^ RD_KEY

  typedef struct {
    int          inst;
    int          mst;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  ba;
    logic        lock;
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, ce_r, ce_f;
  logic [31:0] m_a    [2][2];
  logic [31:0] m_di   [2][2];
  logic [3:0]  m_ba   [2][2];
  logic        m_we   [2][2];
  logic        m_req  [2][2];
  logic        m_lock [2][2];
  wire  [31:0] m_do   [2][2];
  wire         m_busy [2][2];
  wire  [31:0] s_a    [2];
  wire  [31:0] s_di   [2];
  wire  [3:0]  s_ba   [2];
  wire         s_we   [2];
  wire         s_req  [2];
  wire         s_lock [2];
  wire  [1:0]  owner  [2];
  logic [31:0] s_do   [2];
  logic        s_busy [2];

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  int   bsc_ws = 0;
  int   ce_cnt = 0;
  int   issue_ce [2];
  logic ce_slow = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ibus_arbiter #(.RR_MODE(g == 0 ? ARB_FIXED : ARB_RR)) u_dut (
      .CLK(clk), .RST_N(rst_n), .CE_R(ce_r), .CE_F(ce_f),
      .M0_A(m_a[g][0]), .M0_DI(m_di[g][0]), .M0_BA(m_ba[g][0]), .M0_WE(m_we[g][0]),
      .M0_REQ(m_req[g][0]), .M0_LOCK(m_lock[g][0]), .M0_DO(m_do[g][0]), .M0_BUSY(m_busy[g][0]),
      .M1_A(m_a[g][1]), .M1_DI(m_di[g][1]), .M1_BA(m_ba[g][1]), .M1_WE(m_we[g][1]),
      .M1_REQ(m_req[g][1]), .M1_LOCK(m_lock[g][1]), .M1_DO(m_do[g][1]), .M1_BUSY(m_busy[g][1]),
      .S_A(s_a[g]), .S_DI(s_di[g]), .S_BA(s_ba[g]), .S_WE(s_we[g]), .S_REQ(s_req[g]),
      .S_LOCK(s_lock[g]), .S_DO(s_do[g]), .S_BUSY(s_busy[g]), .OWNER(owner[g])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic exp_push(input int inst, input int mst, input logic [31:0] addr, input logic we,
                          input logic [31:0] wdata, input logic [3:0] ba, input logic lock,
                          input logic [31:0] rdata, input int lat);
    exp_t e;
    e.inst = inst; e.mst = mst; e.addr = addr; e.we = we; e.wdata = wdata;
    e.ba = ba; e.lock = lock; e.rdata = rdata; e.lat = lat;
    sb.push_back(e);
  endtask

  // Present one access and wait (bounded) for its completion cycle; REQ stays high afterwards.
  task automatic m_access(input int g, input int n, input logic [31:0] a, input logic we,
                          input logic [31:0] d, input logic [3:0] ba, input logic lock);
    bit got;
    m_a[g][n] = a; m_di[g][n] = d; m_ba[g][n] = ba; m_we[g][n] = we;
    m_lock[g][n] = lock; m_req[g][n] = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clk);
      if (rst_n && ce_r && !m_busy[g][n]) got = 1'b1;
    end
    check("access_done", 32'(got), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic m_idle(input int g, input int n);
    m_req[g][n]  = 1'b0;
    m_lock[g][n] = 1'b0;
  endtask

  // CE_R generator: always on, or one CE_R edge in three while ce_slow is set.
  initial begin : ce_gen
    int div;
    div = 0;
    forever begin
      @(posedge clk);
      #1;
      if (ce_slow) begin
        div  = (div + 1) % 3;
        ce_r = (div == 0);
      end else begin
        ce_r = 1'b1;
      end
    end
  end

  // BSC model: accepts S_REQ, holds BUSY for bsc_ws CE_R edges, returns address-derived data.
  initial begin : bsc_model
    logic        snap_req [2];
    logic [31:0] snap_a   [2];
    logic        active   [2];
    int          cnt      [2];
    logic        snap_ce, snap_rst;
    for (int g = 0; g < 2; g++) begin
      active[g] = 1'b0; cnt[g] = 0; s_busy[g] = 1'b0; s_do[g] = '0; issue_ce[g] = 0;
    end
    forever begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        snap_req[g] = s_req[g];
        snap_a[g]   = s_a[g];
      end
      snap_ce  = ce_r;
      snap_rst = rst_n;
      @(posedge clk);
      #1;
      if (snap_rst && snap_ce) ce_cnt++;
      for (int g = 0; g < 2; g++) begin
        if (!snap_rst || !rst_n) begin
          active[g] = 1'b0;
          s_busy[g] = 1'b0;
        end else if (snap_ce) begin
          if (active[g] && !s_busy[g]) begin
            active[g] = 1'b0;
          end else if (active[g]) begin
            cnt[g]--;
            s_busy[g] = (cnt[g] != 0);
          end else if (snap_req[g]) begin
            active[g]   = 1'b1;
            cnt[g]      = bsc_ws;
            s_busy[g]   = (bsc_ws != 0);
            s_do[g]     = snap_a[g] ^ RD_KEY;
            issue_ce[g] = ce_cnt;
          end
        end
      end
    end
  end

  // Scoreboard monitor: a completion is a CE_R cycle with REQ=1 and BUSY=0.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && ce_r) begin
        for (int g = 0; g < 2; g++) begin
          for (int n = 0; n < 2; n++) begin
            if (m_req[g][n] && !m_busy[g][n]) begin
              if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_completion: inst %0d master %0d completed, expected none", g, n);
              end else begin
                e = sb.pop_front();
                check("cpl_inst",   32'(g), 32'(e.inst));
                check("cpl_master", 32'(n), 32'(e.mst));
                check("cpl_owner",  32'(owner[g]), (e.mst == 0) ? 32'd1 : 32'd2);
                check("cpl_addr",   s_a[g], e.addr);
                check("cpl_we",     32'(s_we[g]), 32'(e.we));
                check("cpl_ba",     32'(s_ba[g]), 32'(e.ba));
                check("cpl_lock",   32'(s_lock[g]), 32'(e.lock));
                if (e.we) check("cpl_wdata", s_di[g], e.wdata);
                else      check("cpl_rdata", m_do[g][n], e.rdata);
                check("cpl_latency", 32'(ce_cnt - issue_ce[g] + 1), 32'(e.lat));
                check("cpl_other_busy", 32'(m_busy[g][1-n]), 32'(m_req[g][1-n]));
              end
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    for (int g = 0; g < 2; g++) begin
      for (int n = 0; n < 2; n++) begin
        m_a[g][n] = '0; m_di[g][n] = '0; m_ba[g][n] = '0;
        m_we[g][n] = 1'b0; m_req[g][n] = 1'b0; m_lock[g][n] = 1'b0;
      end
    end
    rst_n = 1'b0; ce_r = 1'b1; ce_f = 1'b0;
    m_req[0][1] = 1'b1;
    m_req[1][0] = 1'b1;
    step(2);

    // Reset state: idle, slave port quiet, BUSY mirrors REQ.
    check("rst_owner0",  32'(owner[0]), 32'd0);
    check("rst_owner1",  32'(owner[1]), 32'd0);
    check("rst_sreq0",   32'(s_req[0]), 32'd0);
    check("rst_sa1",     s_a[1], 32'd0);
    check("rst_busy0m1", 32'(m_busy[0][1]), 32'd1);
    check("rst_busy0m0", 32'(m_busy[0][0]), 32'd0);
    check("rst_busy1m0", 32'(m_busy[1][0]), 32'd1);
    m_req[0][1] = 1'b0;
    m_req[1][0] = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(1);

    // 1: single M0 read with 3 wait states; grant after one CE_R.
    bsc_ws = 3;
    exp_push(0, 0, 32'h0000_0100, 1'b0, 32'h0, 4'hF, 1'b0, 32'h5A5A_5B5A, 4);
    m_a[0][0] = 32'h0000_0100; m_ba[0][0] = 4'hF; m_we[0][0] = 1'b0; m_req[0][0] = 1'b1;
    step(1);
    check("t1_owner", 32'(owner[0]), 32'd1);
    check("t1_sreq",  32'(s_req[0]), 32'd1);
    check("t1_busy",  32'(m_busy[0][0]), 32'd1);
    m_access(0, 0, 32'h0000_0100, 1'b0, 32'h0, 4'hF, 1'b0);
    m_idle(0, 0);
    step(2);

    // 2: fixed priority, M0 keeps the bus for three accesses, then M1.
    bsc_ws = 1;
    exp_push(0, 0, 32'h0000_1000, 1'b0, 32'h0,         4'hF, 1'b0, 32'h5A5A_4A5A, 2);
    exp_push(0, 0, 32'h0000_2000, 1'b1, 32'hDEAD_0001, 4'h3, 1'b0, 32'h0,         2);
    exp_push(0, 0, 32'h0000_3000, 1'b0, 32'h0,         4'hF, 1'b0, 32'h5A5A_6A5A, 2);
    exp_push(0, 1, 32'h0400_0000, 1'b0, 32'h0,         4'hF, 1'b0, 32'h5E5A_5A5A, 2);
    fork
      begin
        m_access(0, 0, 32'h0000_1000, 1'b0, 32'h0,         4'hF, 1'b0);
        m_access(0, 0, 32'h0000_2000, 1'b1, 32'hDEAD_0001, 4'h3, 1'b0);
        m_access(0, 0, 32'h0000_3000, 1'b0, 32'h0,         4'hF, 1'b0);
        m_idle(0, 0);
      end
      begin
        m_access(0, 1, 32'h0400_0000, 1'b0, 32'h0, 4'hF, 1'b0);
        m_idle(0, 1);
      end
    join
    step(3);

    // 3: round-robin with sparse CE_R; grants alternate M0, M1, M0, M1.
    bsc_ws = 0;
    ce_slow = 1'b1;
    exp_push(1, 0, 32'h0000_1000, 1'b0, 32'h0,         4'hF, 1'b0, 32'h5A5A_4A5A, 1);
    exp_push(1, 1, 32'h0400_0000, 1'b0, 32'h0,         4'hF, 1'b0, 32'h5E5A_5A5A, 1);
    exp_push(1, 0, 32'h0000_2000, 1'b0, 32'h0,         4'hF, 1'b0, 32'h5A5A_7A5A, 1);
    exp_push(1, 1, 32'h0400_0004, 1'b1, 32'h1234_5678, 4'hF, 1'b0, 32'h0,         1);
    fork
      begin
        m_access(1, 0, 32'h0000_1000, 1'b0, 32'h0, 4'hF, 1'b0);
        m_access(1, 0, 32'h0000_2000, 1'b0, 32'h0, 4'hF, 1'b0);
        m_idle(1, 0);
      end
      begin
        m_access(1, 1, 32'h0400_0000, 1'b0, 32'h0,         4'hF, 1'b0);
        m_access(1, 1, 32'h0400_0004, 1'b1, 32'h1234_5678, 4'hF, 1'b0);
        m_idle(1, 1);
      end
    join
    ce_slow = 1'b0;
    step(6);

    // 4: M1 TAS under LOCK; M0 (higher fixed priority) must wait for the unlock.
    bsc_ws = 1;
    exp_push(0, 1, 32'h0600_0000, 1'b0, 32'h0,         4'h1, 1'b1, 32'h5C5A_5A5A, 2);
    exp_push(0, 1, 32'h0600_0000, 1'b1, 32'h0000_0080, 4'h1, 1'b1, 32'h0,         2);
    exp_push(0, 0, 32'h0000_0100, 1'b0, 32'h0,         4'hF, 1'b0, 32'h5A5A_5B5A, 2);
    fork
      begin
        m_access(0, 1, 32'h0600_0000, 1'b0, 32'h0, 4'h1, 1'b1);
        m_req[0][1] = 1'b0;
        step(2);
        check("t4_locked_owner", 32'(owner[0]), 32'd2);
        check("t4_m0_stalled",   32'(m_busy[0][0]), 32'd1);
        m_access(0, 1, 32'h0600_0000, 1'b1, 32'h0000_0080, 4'h1, 1'b1);
        m_idle(0, 1);
        step(1);
        check("t4_unlock_owner", 32'(owner[0]), 32'd1);
      end
      begin : m0_side
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 50 && !seen; t++) begin
          @(negedge clk);
          if (owner[0] == 2'b10) seen = 1'b1;
        end
        check("t4_m1_granted", 32'(seen), 32'd1);
        @(posedge clk);
        #1;
        m_access(0, 0, 32'h0000_0100, 1'b0, 32'h0, 4'hF, 1'b0);
        m_idle(0, 0);
      end
    join
    step(3);

    // 5: register-space accesses back to back, each completing one CE_R after issue.
    bsc_ws = 0;
    exp_push(0, 0, 32'hFFFF_FFE8, 1'b0, 32'h0,         4'hF, 1'b0, 32'hA5A5_A5B2, 1);
    exp_push(0, 0, 32'hFFFF_FFE8, 1'b1, 32'h0000_00FF, 4'hF, 1'b0, 32'h0,         1);
    m_access(0, 0, 32'hFFFF_FFE8, 1'b0, 32'h0,         4'hF, 1'b0);
    m_access(0, 0, 32'hFFFF_FFE8, 1'b1, 32'h0000_00FF, 4'hF, 1'b0);
    m_idle(0, 0);
    step(1);
    check("t5_sreq_idle", 32'(s_req[0]), 32'd0);
    step(2);

    // 6: asynchronous reset in the middle of a long access, then normal arbitration.
    bsc_ws = 10;
    m_a[0][0] = 32'h0000_3000; m_we[0][0] = 1'b0; m_ba[0][0] = 4'hF; m_req[0][0] = 1'b1;
    step(4);
    check("t6_pre_sreq", 32'(s_req[0]), 32'd1);
    check("t6_pre_busy", 32'(m_busy[0][0]), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_rst_owner", 32'(owner[0]), 32'd0);
    check("t6_rst_sreq",  32'(s_req[0]), 32'd0);
    check("t6_rst_sa",    s_a[0], 32'd0);
    check("t6_rst_busy",  32'(m_busy[0][0]), 32'd1);
    m_req[0][0] = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
    bsc_ws = 0;
    exp_push(0, 0, 32'h0000_0100, 1'b0, 32'h0, 4'hF, 1'b0, 32'h5A5A_5B5A, 1);
    exp_push(0, 1, 32'h0400_0004, 1'b0, 32'h0, 4'hF, 1'b0, 32'h5E5A_5A5E, 1);
    fork
      begin
        m_access(0, 0, 32'h0000_0100, 1'b0, 32'h0, 4'hF, 1'b0);
        m_idle(0, 0);
      end
      begin
        m_access(0, 1, 32'h0400_0004, 1'b0, 32'h0, 4'hF, 1'b0);
        m_idle(0, 1);
      end
    join
    step(3);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
